// File: rtl/debounce_bank.sv
// Bank of switch and push-button debouncers. Each input is double-flop synchronised and
// debounced. Buttons also get press/release pulses and an optional auto-repeat.

module debounce_core #(
  parameter int N             = 1,
  parameter int STABLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] upd
);
  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [CW-1:0] cnt [N];

  // upd marks the edge at which a channel's held level flips.
  always_comb begin
    // NOTE: default first so no path leaves upd unassigned (avoids an inferred latch).
    upd = '0;
    for (int i = 0; i < N; i++) begin
      upd[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      // NOTE: the counter array is cleared too; it is real state, not a RAM.
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking so sync2 takes the old sync1, forming a true two-flop chain.
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
endmodule

module debounce_bank #(
  parameter int NUM_SW        = 8,
  parameter int NUM_BTN       = 5,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_SW-1:0]  sw_out,
  output logic [NUM_SW-1:0]  sw_change,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RPT} rpt_state_e;

  logic [NUM_SW-1:0]  sw_upd;
  logic [NUM_BTN-1:0] btn_upd;

  debounce_core #(.N(NUM_SW), .STABLE_CYCLES(STABLE_CYCLES)) u_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw_in),
    .level (sw_out),
    .upd   (sw_upd)
  );

  debounce_core #(.N(NUM_BTN), .STABLE_CYCLES(STABLE_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_in),
    .level (btn_level),
    .upd   (btn_upd)
  );

  // Pulses are registered on the same edge the level flips, so they coincide with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_change   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      sw_change   <= sw_upd;
      btn_press   <= btn_upd & ~btn_level;
      btn_release <= btn_upd & btn_level;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

      for (genvar b = 0; b < NUM_BTN; b++) begin : g_ch
        rpt_state_e    state, state_nxt;
        logic [RW-1:0] rcnt, rcnt_nxt;
        logic          rep_q, rep_nxt;

        // Entering WAIT on the press edge itself puts the first repeat REPEAT_DELAY after btn_press.
        always_comb begin
          state_nxt = state;
          rcnt_nxt  = rcnt;
          rep_nxt   = 1'b0;
          if (btn_upd[b] && btn_level[b]) begin
            state_nxt = R_IDLE;
            rcnt_nxt  = '0;
          end else if (btn_upd[b]) begin
            state_nxt = R_WAIT;
            rcnt_nxt  = '0;
          end else begin
            case (state)
              R_WAIT: begin
                if (rcnt == DLY_LAST) begin
                  rep_nxt   = 1'b1;
                  rcnt_nxt  = '0;
                  state_nxt = R_RPT;
                end else begin
                  rcnt_nxt = rcnt + RW'(1);
                end
              end
              R_RPT: begin
                if (rcnt == PER_LAST) begin
                  rep_nxt  = 1'b1;
                  rcnt_nxt = '0;
                end else begin
                  rcnt_nxt = rcnt + RW'(1);
                end
              end
              default: ;
            endcase
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            state <= R_IDLE;
            rcnt  <= '0;
            rep_q <= 1'b0;
          end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            rep_q <= rep_nxt;
          end
        end

        assign btn_repeat[b] = rep_q;
      end
    end else begin : g_no_rpt
      assign btn_repeat = '0;
    end
  endgenerate
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3;
// a second instance with auto-repeat disabled shares the inputs.

module tb_debounce_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_in = '1;
  logic [4:0] btn_in = '1;

  logic [7:0] sw_out, sw_change, sw_out0, sw_change0;
  logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [4:0] btn_level0, btn_press0, btn_release0, btn_repeat0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_bank #(.NUM_SW(8), .NUM_BTN(5), .STABLE_CYCLES(4), .REPEAT_EN(1),
                  .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in),
    .sw_out(sw_out), .sw_change(sw_change), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  debounce_bank #(.NUM_SW(8), .NUM_BTN(5), .STABLE_CYCLES(4), .REPEAT_EN(0),
                  .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in),
    .sw_out(sw_out0), .sw_change(sw_change0), .btn_level(btn_level0),
    .btn_press(btn_press0), .btn_release(btn_release0), .btn_repeat(btn_repeat0)
  );

  // Advance one clock; outputs are observed 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sw_in  = '0;
    btn_in = '0;
    rst_n  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [36:0] all_out;
    logic [7:0]  exp_sw, exp_swc;
    logic [4:0]  exp_bl, exp_bp;
    rst_n  = 1'b0;
    sw_in  = '1;
    btn_in = '1;
    step(); step(); step();
    all_out = {sw_out, sw_change, btn_level, btn_press, btn_release, btn_repeat};
    if (all_out !== 37'd0) begin
      $display("FAIL reset_outputs got=%h want=0", all_out); n_err++;
    end
    n_vec++;
    all_out = {sw_out0, sw_change0, btn_level0, btn_press0, btn_release0, btn_repeat0};
    if (all_out !== 37'd0) begin
      $display("FAIL reset_outputs_norpt got=%h want=0", all_out); n_err++;
    end
    n_vec++;
    rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_sw  = (k >= 5) ? 8'hff : 8'h00;
      exp_swc = (k == 5) ? 8'hff : 8'h00;
      exp_bl  = (k >= 5) ? 5'h1f : 5'h00;
      exp_bp  = (k == 5) ? 5'h1f : 5'h00;
      if (sw_out !== exp_sw || sw_change !== exp_swc) begin
        $display("FAIL reset_release_sw edge=%0d got=%h/%h want=%h/%h", k, sw_out, sw_change,
                 exp_sw, exp_swc); n_err++;
      end
      n_vec++;
      if (btn_level !== exp_bl || btn_press !== exp_bp) begin
        $display("FAIL reset_release_btn edge=%0d got=%h/%h want=%h/%h", k, btn_level, btn_press,
                 exp_bl, exp_bp); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_single_press();
    logic [4:0] exp_bl, exp_bp;
    do_reset();
    btn_in[0] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      exp_bl = (k >= 5) ? 5'h01 : 5'h00;
      exp_bp = (k == 5) ? 5'h01 : 5'h00;
      if (btn_level !== exp_bl || btn_press !== exp_bp || btn_release !== 5'h00
          || sw_out !== 8'h00) begin
        $display("FAIL single_press edge=%0d got=%h/%h/%h want=%h/%h/00", k, btn_level,
                 btn_press, btn_release, exp_bl, exp_bp); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp_bl, exp_bp;
    do_reset();
    btn_in[1] = 1'b1;
    step(); step(); step();
    btn_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
        $display("FAIL short_glitch cyc=%0d got=%h/%h want=00/00", k, btn_level, btn_press);
        n_err++;
      end
      n_vec++;
    end
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = (i % 2 == 0);
      step();
      if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
        $display("FAIL toggle_quiet cyc=%0d got=%h/%h want=00/00", i, btn_level, btn_press);
        n_err++;
      end
      n_vec++;
    end
    btn_in[1] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_bl = (k >= 5) ? 5'h02 : 5'h00;
      exp_bp = (k == 5) ? 5'h02 : 5'h00;
      if (btn_level !== exp_bl || btn_press !== exp_bp) begin
        $display("FAIL toggle_settle edge=%0d got=%h/%h want=%h/%h", k, btn_level, btn_press,
                 exp_bl, exp_bp); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_repeat();
    logic [4:0] exp_rep, exp_rel, exp_bl;
    do_reset();
    btn_in[2] = 1'b1;
    for (int k = 0; k <= 5; k++) step();
    if (btn_press !== 5'h04) begin
      $display("FAIL repeat_press got=%h want=04", btn_press); n_err++;
    end
    n_vec++;
    // Release is applied so the falling edge lands at t=37, a slot where a repeat would fall.
    for (int t = 1; t <= 45; t++) begin
      if (t == 32) btn_in[2] = 1'b0;
      step();
      exp_rep = (t >= 10 && t < 37 && (t - 10) % 3 == 0) ? 5'h04 : 5'h00;
      exp_rel = (t == 37) ? 5'h04 : 5'h00;
      exp_bl  = (t < 37) ? 5'h04 : 5'h00;
      if (btn_repeat !== exp_rep) begin
        $display("FAIL repeat_pulse t=%0d got=%h want=%h", t, btn_repeat, exp_rep); n_err++;
      end
      n_vec++;
      if (btn_release !== exp_rel || btn_level !== exp_bl) begin
        $display("FAIL repeat_release t=%0d got=%h/%h want=%h/%h", t, btn_release, btn_level,
                 exp_rel, exp_bl); n_err++;
      end
      n_vec++;
      if (btn_repeat0 !== 5'h00) begin
        $display("FAIL repeat_disabled t=%0d got=%h want=00", t, btn_repeat0); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_sw, exp_swc;
    do_reset();
    sw_in = 8'h81;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_sw  = (k >= 5) ? 8'h81 : 8'h00;
      exp_swc = (k == 5) ? 8'h81 : 8'h00;
      if (sw_out !== exp_sw || sw_change !== exp_swc) begin
        $display("FAIL simul_rise edge=%0d got=%h/%h want=%h/%h", k, sw_out, sw_change,
                 exp_sw, exp_swc); n_err++;
      end
      n_vec++;
    end
    sw_in = 8'h00;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_sw  = (k >= 5) ? 8'h00 : 8'h81;
      exp_swc = (k == 5) ? 8'h81 : 8'h00;
      if (sw_out !== exp_sw || sw_change !== exp_swc) begin
        $display("FAIL simul_fall edge=%0d got=%h/%h want=%h/%h", k, sw_out, sw_change,
                 exp_sw, exp_swc); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] exp_bp;
    logic [7:0] exp_swc;
    do_reset();
    sw_in[1] = 1'b1;
    for (int k = 0; k <= 6; k++) step();
    if (sw_out !== 8'h02) begin
      $display("FAIL midrst_setup got=%h want=02", sw_out); n_err++;
    end
    n_vec++;
    btn_in[3] = 1'b1;
    for (int k = 0; k <= 3; k++) step();  // button counter now at 2
    #2;
    rst_n = 1'b0;
    #1;
    if (sw_out !== 8'h00 || btn_level !== 5'h00 || sw_out0 !== 8'h00) begin
      $display("FAIL midrst_async got=%h/%h/%h want=00/00/00", sw_out, btn_level, sw_out0);
      n_err++;
    end
    n_vec++;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_bp  = (k == 5) ? 5'h08 : 5'h00;
      exp_swc = (k == 5) ? 8'h02 : 8'h00;
      if (btn_press !== exp_bp || sw_change !== exp_swc) begin
        $display("FAIL midrst_repress edge=%0d got=%h/%h want=%h/%h", k, btn_press, sw_change,
                 exp_bp, exp_swc); n_err++;
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
